mlp_axil_regs: RTL and testbench
================================

# mlp_axil_regs

AXI4-Lite slave register file that holds the MLP accelerator's run-time configuration (layer sizes, enable, data-ready) and exposes core status to the processor. It is the responding end of the configuration bus whose master is the PS/testbench. It sits beside the AXI-Stream datapath and feeds the layer sequencer with static configuration and a start pulse.

## Interface
- C_S00_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S00_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots
- s00_axi_aclk  in  1  single clock for all logic
- s00_axi_aresetn  in  1  reset, asynchronous, active-low
- s00_axi_awaddr / awprot / awvalid  in  ADDR_W / 3 / 1  write address; awprot ignored
- s00_axi_awready  out  1  write-address accept
- s00_axi_wdata / wstrb / wvalid  in  32 / 4 / 1  write data, byte strobes
- s00_axi_wready  out  1  write-data accept
- s00_axi_bresp / bvalid  out  2 / 1  write response; s00_axi_bready in 1
- s00_axi_araddr / arprot / arvalid  in  ADDR_W / 3 / 1  read address; arprot ignored
- s00_axi_arready  out  1  read-address accept
- s00_axi_rdata / rresp / rvalid  out  32 / 2 / 1  read data; s00_axi_rready in 1
- cfg_input_num / cfg_hidden_num / cfg_output_num  out  32 each  register contents
- cfg_en, cfg_dat_rdy  out  1 each  CONTROL bits 0 and 1
- start_pulse  out  1  one-cycle pulse on EN 0->1
- core_busy, core_done  in  1 each  status from sequencer (done is a 1-cycle pulse)
- core_layer  in  3  current layer index

## Operation
- Map (addr[4:2]): 0x00 INPUT_NUM rw; 0x04 HIDDEN_NUM rw, bytes [7:0]..[31:24] = hidden1..hidden4; 0x08 OUTPUT_NUM rw; 0x0C CONTROL rw, bit0 EN, bit1 DAT_RDY, bits[31:2] read 0; 0x10 STATUS: bit0 busy (live), bit1 done (sticky, W1C), bits[4:2] layer (live); 0x14–0x1C unmapped.
- addr[1:0] ignored. Writes honour wstrb per byte; wstrb=0 is a legal no-op with OKAY.
- Unmapped write: no state change, bresp=SLVERR(2'b10). Unmapped read: rdata=0, rresp=SLVERR. All else OKAY(2'b00).
- Write path: AW and W captured independently into one-entry holding buffers, either order, any skew. Write commits on the edge where both buffers are full (or both handshakes complete in the same cycle); bvalid rises on that edge.
- start_pulse: high for exactly the cycle after a commit that changes EN from 0 to 1. Rewriting EN=1 while already 1: no pulse.
- done: set by core_done, cleared by write with wdata[1]=1 to STATUS (byte0 strobe). Same-cycle set and clear: set wins.
- Reads and writes are independent; a same-cycle read of a register being written returns the old value.

## Timing
- Reset: awready=wready=arready=0 during reset, bvalid=rvalid=0, bresp=rresp=0, rdata=0, all cfg_* = 0, start_pulse=0, done=0.
- awready = !aw_full && !bvalid; wready = !w_full && !bvalid; no combinational path from any valid to any ready.
- Back-to-back best case: AW+W handshake cycle N -> bvalid in N+1 -> with bready=1, readies return in N+2. Throughput one write per 2 cycles.
- bvalid, bresp held stable until bready; buffers cannot accept a new write while bvalid=1.
- arready = !rvalid. Read handshake cycle N -> rvalid, rdata, rresp in N+1, held stable until rready. One read per 2 cycles.
- cfg_* update on the commit edge (visible in N+1, same cycle as bvalid).
- Reset asserted mid-transaction: all buffers and pending responses dropped, no response issued after release.

## Structure
- Package mlp_axil_pkg: register offsets, CONTROL/STATUS bit positions, RESP_OKAY/RESP_SLVERR constants, hidden-field byte positions.
- One sub-module natural: axil_wr_join (AW/W one-entry buffers, join, B response); register decode and read mux stay in the top.

## Test plan
- Reset then read all 8 slots -> 0x00–0x10 return 0 with OKAY, 0x14–0x1C return 0 with SLVERR.
- Write INPUT_NUM=784, HIDDEN_NUM=0x00001414 (20,20), OUTPUT_NUM=10 -> read back identical, cfg_* match from cycle after bvalid.
- W presented 3 cycles before AW, then AW 3 cycles before W -> each commits once, single bvalid; bready held low 5 cycles -> bvalid/bresp stable, no readies meanwhile.
- Write CONTROL=0x3 -> start_pulse high exactly one cycle, cfg_en=cfg_dat_rdy=1; write 0x3 again -> no pulse; write 0x0 then 0x1 -> one pulse.
- Pulse core_done; read STATUS -> bit1=1; write 0x2 to STATUS in same cycle as a second core_done -> bit1 stays 1; write 0x2 alone -> bit1=0.
- wstrb=4'b0010 write 0xAABBCCDD to INPUT_NUM=0 -> reads 0x0000CC00; write to 0x18 -> SLVERR, no register changed.

Source files
------------

// File: rtl/mlp_axil_pkg.sv
// Shared constants for the MLP accelerator AXI4-Lite register file:
// register slots, CONTROL/STATUS bit positions, response codes, helpers.
package mlp_axil_pkg;

  localparam int DATA_W = 32;

  // Word slot index = byte offset [4:2]
  localparam logic [2:0] IDX_INPUT   = 3'd0;
  localparam logic [2:0] IDX_HIDDEN  = 3'd1;
  localparam logic [2:0] IDX_OUTPUT  = 3'd2;
  localparam logic [2:0] IDX_CONTROL = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;

  localparam logic [4:0] OFF_INPUT   = 5'h00;
  localparam logic [4:0] OFF_HIDDEN  = 5'h04;
  localparam logic [4:0] OFF_OUTPUT  = 5'h08;
  localparam logic [4:0] OFF_CONTROL = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_DAT_RDY   = 1;
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_LAYER_LSB = 2;

  // Hidden layer sizes packed one per byte of HIDDEN_NUM
  localparam int HID1_LSB = 0;
  localparam int HID2_LSB = 8;
  localparam int HID3_LSB = 16;
  localparam int HID4_LSB = 24;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DATA_W-1:0] apply_strb(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] data,
    input logic [3:0]        strb
  );
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mlp_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS (master) and the register file
// (slave): AW, W, B, AR and R channels.
interface mlp_axil_regs_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mlp_axil_regs_wr_join.sv
// AW/W one-entry holding buffers joined into a single write commit,
// plus the B response. Ports: AW/W/B channel, commit strobe + payload.
module axil_wr_join
  import mlp_axil_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  input  logic              bready,
  output logic              bvalid,
  output logic [1:0]        bresp,
  input  logic              slverr,
  output logic              commit,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data,
  output logic [3:0]        strb
);
  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-1:0] aw_buf;
  logic [31:0]       w_buf;
  logic [3:0]        s_buf;
  logic              aw_hs;
  logic              w_hs;

  assign awready = live && !aw_full && !bvalid;
  assign wready  = live && !w_full && !bvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Commit as soon as both halves are present, buffered or live
  assign commit = (aw_full || aw_hs) && (w_full || w_hs);
  assign addr   = aw_full ? aw_buf : awaddr;
  assign data   = w_full ? w_buf : wdata;
  assign strb   = w_full ? s_buf : wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_buf  <= '0;
      w_buf   <= '0;
      s_buf   <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
      end else if (aw_hs) begin
        aw_full <= 1'b1;
        aw_buf  <= awaddr;
      end
      if (commit) begin
        w_full <= 1'b0;
      end else if (w_hs) begin
        w_full <= 1'b1;
        w_buf  <= wdata;
        s_buf  <= wstrb;
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= slverr ? RESP_SLVERR : RESP_OKAY;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/mlp_axil_regs.sv
// AXI4-Lite register file for MLP configuration and core status.
// Ports: clk/rst, slave bus, cfg_* outputs, start_pulse, core status in.
module mlp_axil_regs
  import mlp_axil_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  mlp_axil_regs_if.slave                  s00_axi,
  output logic [C_S00_AXI_DATA_WIDTH-1:0] cfg_input_num,
  output logic [C_S00_AXI_DATA_WIDTH-1:0] cfg_hidden_num,
  output logic [C_S00_AXI_DATA_WIDTH-1:0] cfg_output_num,
  output logic                            cfg_en,
  output logic                            cfg_dat_rdy,
  output logic                            start_pulse,
  input  logic                            core_busy,
  input  logic                            core_done,
  input  logic [2:0]                      core_layer
);
  localparam int AW = C_S00_AXI_ADDR_WIDTH;

  logic          live;
  logic          done;
  logic          commit;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic [7:0]    wsel;
  logic          wr_err;
  logic          en_nxt;
  logic [7:0]    rsel;
  logic [31:0]   rd_data;
  logic          rd_err;
  logic          ar_hs;
  logic          unused_bits;

  // Readies stay low until the first edge after reset release
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) live <= 1'b0;
    else                  live <= 1'b1;
  end

  axil_wr_join #(.ADDR_W(AW)) u_wr (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .live    (live),
    .awaddr  (s00_axi.awaddr),
    .awvalid (s00_axi.awvalid),
    .awready (s00_axi.awready),
    .wdata   (s00_axi.wdata),
    .wstrb   (s00_axi.wstrb),
    .wvalid  (s00_axi.wvalid),
    .wready  (s00_axi.wready),
    .bready  (s00_axi.bready),
    .bvalid  (s00_axi.bvalid),
    .bresp   (s00_axi.bresp),
    .slverr  (wr_err),
    .commit  (commit),
    .addr    (wr_addr),
    .data    (wr_data),
    .strb    (wr_strb)
  );

  assign wsel   = 8'b1 << wr_addr[4:2];
  assign wr_err = wr_addr[4:2] > IDX_STATUS;
  assign en_nxt = wr_strb[0] ? wr_data[CTRL_EN] : cfg_en;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cfg_input_num  <= '0;
      cfg_hidden_num <= '0;
      cfg_output_num <= '0;
      cfg_en         <= 1'b0;
      cfg_dat_rdy    <= 1'b0;
      start_pulse    <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (commit) begin
        unique case (1'b1)
          wsel[IDX_INPUT]:
            cfg_input_num <= apply_strb(cfg_input_num, wr_data, wr_strb);
          wsel[IDX_HIDDEN]:
            cfg_hidden_num <= apply_strb(cfg_hidden_num, wr_data, wr_strb);
          wsel[IDX_OUTPUT]:
            cfg_output_num <= apply_strb(cfg_output_num, wr_data, wr_strb);
          wsel[IDX_CONTROL]: begin
            cfg_en      <= en_nxt;
            start_pulse <= en_nxt && !cfg_en;
            if (wr_strb[0]) cfg_dat_rdy <= wr_data[CTRL_DAT_RDY];
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky done: a new core_done beats a same-cycle W1C
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)
      done <= 1'b0;
    else if (core_done)
      done <= 1'b1;
    else if (commit && wsel[IDX_STATUS] && wr_strb[0] && wr_data[STAT_DONE])
      done <= 1'b0;
  end

  assign rsel = 8'b1 << s00_axi.araddr[4:2];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      rsel[IDX_INPUT]:   rd_data = cfg_input_num;
      rsel[IDX_HIDDEN]:  rd_data = cfg_hidden_num;
      rsel[IDX_OUTPUT]:  rd_data = cfg_output_num;
      rsel[IDX_CONTROL]: begin
        rd_data[CTRL_EN]      = cfg_en;
        rd_data[CTRL_DAT_RDY] = cfg_dat_rdy;
      end
      rsel[IDX_STATUS]: begin
        rd_data[STAT_BUSY]             = core_busy;
        rd_data[STAT_DONE]             = done;
        rd_data[STAT_LAYER_LSB +: 3]   = core_layer;
      end
      default: rd_err = 1'b1;
    endcase
  end

  assign s00_axi.arready = live && !s00_axi.rvalid;
  assign ar_hs = s00_axi.arvalid && s00_axi.arready;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi.rvalid <= 1'b0;
      s00_axi.rdata  <= '0;
      s00_axi.rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s00_axi.rvalid <= 1'b1;
      s00_axi.rdata  <= rd_data;
      s00_axi.rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s00_axi.rready) begin
      s00_axi.rvalid <= 1'b0;
    end
  end

  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                         wr_addr[1:0], s00_axi.araddr[1:0]};
endmodule

// File: tb/tb_mlp_axil_regs.sv
// Self-checking bench for mlp_axil_regs: register-level model,
// per-cycle cfg/start_pulse compare, directed AXI-Lite transactions.
module tb_mlp_axil_regs;
  import mlp_axil_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlp_axil_regs_if #(.ADDR_W(5)) bus ();

  logic [31:0] cfg_input_num;
  logic [31:0] cfg_hidden_num;
  logic [31:0] cfg_output_num;
  logic        cfg_en;
  logic        cfg_dat_rdy;
  logic        start_pulse;
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  logic [2:0]  core_layer = 3'd0;

  mlp_axil_regs #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(5)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (bus.slave),
    .cfg_input_num   (cfg_input_num),
    .cfg_hidden_num  (cfg_hidden_num),
    .cfg_output_num  (cfg_output_num),
    .cfg_en          (cfg_en),
    .cfg_dat_rdy     (cfg_dat_rdy),
    .start_pulse     (start_pulse),
    .core_busy       (core_busy),
    .core_done       (core_done),
    .core_layer      (core_layer)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cyc = -1;
  int npulse = 0;

  // Model state: registers as plain words
  logic [31:0] m_num [0:2];
  logic        m_en;
  logic        m_rdy;
  logic        m_done;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (start_pulse === 1'b1) npulse <= npulse + 1;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_num[i] = '0;
    m_en = 1'b0;
    m_rdy = 1'b0;
    m_done = 1'b0;
    pulse_cyc = -1;
  endtask

  function automatic logic [1:0] m_resp(input logic [4:0] a);
    return (a >= 5'h14) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int k;
    k = int'(a) / 4;
    if (k < 3) return m_num[k];
    if (k == 3) return {30'd0, m_rdy, m_en};
    if (k == 4) return {27'd0, core_layer, m_done, core_busy};
    return 32'd0;
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    int k;
    k = int'(a) / 4;
    if (k < 3) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_num[k][8*b +: 8] = d[8*b +: 8];
    end else if (k == 3 && s[0]) begin
      if (d[0] && !m_en) pulse_cyc = cyc;
      m_en = d[0];
      m_rdy = d[1];
    end else if (k == 4 && s[0] && d[1]) begin
      m_done = 1'b0;
    end
  endtask

  // Continuous compare of the configuration outputs
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cfg_input_num", cfg_input_num, m_num[0]);
      chk("cfg_hidden_num", cfg_hidden_num, m_num[1]);
      chk("cfg_output_num", cfg_output_num, m_num[2]);
      chk("cfg_en", {31'd0, cfg_en}, {31'd0, m_en});
      chk("cfg_dat_rdy", {31'd0, cfg_dat_rdy}, {31'd0, m_rdy});
      chk("start_pulse", {31'd0, start_pulse},
          {31'd0, cyc == pulse_cyc});
    end
  end

  task automatic aw_chan(input logic [4:0] a, input int dly);
    bit hs = 0;
    int t = 0;
    repeat (dly) @(posedge clk);
    #1;
    bus.awaddr = a;
    bus.awvalid = 1'b1;
    while (!hs && t < 20) begin
      @(negedge clk);
      hs = bus.awready;
      @(posedge clk);
      t++;
    end
    #1 bus.awvalid = 1'b0;
    if (!hs) begin
      errors++;
      $display("FAIL aw_timeout addr %h", a);
    end
  endtask

  task automatic w_chan(input logic [31:0] d, input logic [3:0] s,
                        input int dly);
    bit hs = 0;
    int t = 0;
    repeat (dly) @(posedge clk);
    #1;
    bus.wdata = d;
    bus.wstrb = s;
    bus.wvalid = 1'b1;
    while (!hs && t < 20) begin
      @(negedge clk);
      hs = bus.wready;
      @(posedge clk);
      t++;
    end
    #1 bus.wvalid = 1'b0;
    if (!hs) begin
      errors++;
      $display("FAIL w_timeout data %h", d);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly,
                           input int w_dly, input int b_dly);
    fork
      aw_chan(a, aw_dly);
      w_chan(d, s, w_dly);
    join
    m_write(a, d, s);
    chk("bvalid_up", {31'd0, bus.bvalid}, 32'd1);
    chk("bresp", {30'd0, bus.bresp}, {30'd0, m_resp(a)});
    repeat (b_dly) begin
      @(negedge clk);
      chk("bvalid_hold", {31'd0, bus.bvalid}, 32'd1);
      chk("bresp_hold", {30'd0, bus.bresp}, {30'd0, m_resp(a)});
      chk("rdy_blocked", {30'd0, bus.awready, bus.wready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.bready = 1'b1;
    @(posedge clk);
    #1 bus.bready = 1'b0;
    chk("bvalid_down", {31'd0, bus.bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    bit hs = 0;
    int t = 0;
    logic [31:0] e;
    bus.araddr = a;
    bus.arvalid = 1'b1;
    while (!hs && t < 20) begin
      @(negedge clk);
      hs = bus.arready;
      @(posedge clk);
      t++;
    end
    #1 bus.arvalid = 1'b0;
    if (!hs) begin
      errors++;
      $display("FAIL ar_timeout addr %h", a);
    end
    e = m_read(a);
    d = bus.rdata;
    chk("rvalid", {31'd0, bus.rvalid}, 32'd1);
    chk("rdata", bus.rdata, e);
    chk("rresp", {30'd0, bus.rresp}, {30'd0, m_resp(a)});
    @(negedge clk);
    chk("rdata_hold", bus.rdata, e);
    chk("arready_blocked", {31'd0, bus.arready}, 32'd0);
    @(posedge clk);
    #1 bus.rready = 1'b1;
    @(posedge clk);
    #1 bus.rready = 1'b0;
    chk("rvalid_down", {31'd0, bus.rvalid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int p0;
    bus.awaddr = '0;
    bus.awprot = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0;
    bus.arprot = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    m_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies",
        {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
    chk("rst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    chk("rst_resps", {28'd0, bus.bresp, bus.rresp}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_cfg", cfg_input_num | cfg_hidden_num | cfg_output_num,
        32'd0);
    chk("rst_bits", {29'd0, cfg_en, cfg_dat_rdy, start_pulse}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), d);
      chk("reset_read_lit", d, 32'd0);
    end

    axi_write(OFF_INPUT, 32'd784, 4'hF, 0, 0, 0);
    axi_write(OFF_HIDDEN, 32'h0000_1414, 4'hF, 0, 0, 0);
    axi_write(OFF_OUTPUT, 32'd10, 4'hF, 0, 0, 0);
    axi_read(OFF_INPUT, d);
    chk("input_lit", d, 32'd784);
    axi_read(OFF_HIDDEN, d);
    chk("hidden_lit", d, 32'h0000_1414);
    axi_read(OFF_OUTPUT, d);
    chk("output_lit", d, 32'd10);

    axi_write(OFF_OUTPUT, 32'd12, 4'hF, 3, 0, 5);
    axi_write(OFF_INPUT, 32'd100, 4'hF, 0, 3, 5);
    chk("skew_lit", cfg_output_num + cfg_input_num, 32'd112);

    p0 = npulse;
    axi_write(OFF_CONTROL, 32'h3, 4'hF, 0, 0, 0);
    chk("pulse_first", 32'(npulse - p0), 32'd1);
    chk("ctrl_bits_lit", {30'd0, cfg_dat_rdy, cfg_en}, 32'd3);
    axi_write(OFF_CONTROL, 32'h3, 4'hF, 0, 0, 0);
    chk("pulse_rewrite", 32'(npulse - p0), 32'd1);
    axi_write(OFF_CONTROL, 32'h0, 4'hF, 0, 0, 0);
    axi_write(OFF_CONTROL, 32'h1, 4'hF, 0, 0, 0);
    chk("pulse_again", 32'(npulse - p0), 32'd2);
    axi_read(OFF_CONTROL, d);
    chk("control_lit", d, 32'h1);

    core_done = 1'b1;
    @(posedge clk);
    #1 core_done = 1'b0;
    m_done = 1'b1;
    axi_read(OFF_STATUS, d);
    chk("done_set_lit", d, 32'h2);
    fork
      axi_write(OFF_STATUS, 32'h2, 4'h1, 0, 0, 0);
      begin
        core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    join
    m_done = 1'b1;
    core_busy = 1'b1;
    core_layer = 3'd5;
    axi_read(OFF_STATUS, d);
    chk("done_wins_lit", d, 32'h17);
    axi_write(OFF_STATUS, 32'h2, 4'h1, 0, 0, 0);
    axi_read(OFF_STATUS, d);
    chk("done_clr_lit", d, 32'h15);

    axi_write(OFF_INPUT, 32'h0, 4'hF, 0, 0, 0);
    axi_write(OFF_INPUT, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
    axi_read(OFF_INPUT, d);
    chk("strb_lit", d, 32'h0000_CC00);
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(OFF_OUTPUT, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) axi_read(5'(i * 4), d);
    chk("unmapped_lit", cfg_output_num, 32'd12);

    bus.awaddr = OFF_INPUT;
    bus.awvalid = 1'b1;
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    axi_write(OFF_OUTPUT, 32'h55, 4'hF, 3, 0, 0);
    axi_read(OFF_INPUT, d);
    chk("post_rst_input_lit", d, 32'd0);
    axi_read(OFF_OUTPUT, d);
    chk("post_rst_output_lit", d, 32'h55);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
